// File: rtl/pipe_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipe_ctrl_pkg
// Shared types and constants for the PC / pipeline-control slice.
//   state_e     : control FSM states (RUN, STALL, SQUASH)
//   INST_BYTES  : sequential PC increment in bytes
//   REG_W       : register-specifier width
// ---------------------------------------------------------------------------
package pipe_ctrl_pkg;

  localparam int INST_BYTES = 4;
  localparam int REG_W      = 5;

  typedef enum logic [1:0] {
    RUN    = 2'd0,  // normal operation
    STALL  = 2'd1,  // second cycle of a load-use stall, hazard check suppressed
    SQUASH = 2'd2   // cycle after a redirect, IF/ID holds a flushed slot
  } state_e;

endpackage : pipe_ctrl_pkg

// File: rtl/lu_hazard_detect.sv
// ---------------------------------------------------------------------------
// lu_hazard_detect
// Purely combinational load-use hazard compare between the load in ID/EX and
// the source registers of the instruction in IF/ID.
// Ports:
//   ex_mem_read_i : ID/EX instruction is a load
//   ex_rt_i       : load destination register
//   id_rs_i       : IF/ID rs
//   id_rt_i       : IF/ID rt
//   id_uses_rt_i  : IF/ID instruction reads rt as a source
//   hazard_o      : 1 = the IF/ID instruction needs the loaded value
// ---------------------------------------------------------------------------
module lu_hazard_detect
  import pipe_ctrl_pkg::*;
#(
  parameter int W = REG_W
) (
  input  logic         ex_mem_read_i,
  input  logic [W-1:0] ex_rt_i,
  input  logic [W-1:0] id_rs_i,
  input  logic [W-1:0] id_rt_i,
  input  logic         id_uses_rt_i,
  output logic         hazard_o
);

  // Register 0 is hard-wired zero, so a load targeting it never creates a dependency.
  assign hazard_o = ex_mem_read_i && (ex_rt_i != '0) &&
                    ((ex_rt_i == id_rs_i) || (id_uses_rt_i && (ex_rt_i == id_rt_i)));

endmodule : lu_hazard_detect

// File: rtl/next_pc_ctrl.sv
// ---------------------------------------------------------------------------
// next_pc_ctrl
// Chooses the next PC value and the PC / IF/ID / ID/EX control strobes every
// cycle: sequential fetch, branch/jump redirect and load-use stall. Keeps
// saturating stall and redirect counters for debug.
// Control outputs are combinational from state + inputs; only the FSM state
// and the counters are registered.
//
// Optional build macro: NEXT_PC_MEM_WAIT_EN
//   Adds input imem_ready. While it is low (and neither rst nor br_taken is
//   active) the PC and IF/ID hold, IF/ID is flushed, state and counters are
//   unchanged. A branch seen while not ready is parked in a pending-redirect
//   register and applied once imem_ready returns.
//
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   pc_cur         : current PC register value
//   ex_mem_read    : ID/EX holds a load;  ex_rt: its destination
//   id_rs, id_rt   : IF/ID source registers; id_uses_rt: rt is a source
//   br_taken       : EX branch resolved taken; br_target: its target
//   jmp_valid      : ID jump decoded; jmp_target: its target
//   imem_ready     : (NEXT_PC_MEM_WAIT_EN only) instruction memory ready
//   pc_next        : next PC value
//   pc_write       : PC loads pc_next
//   ifid_write     : IF/ID loads
//   ifid_flush     : IF/ID cleared to NOP
//   idex_bubble    : ID/EX loads a NOP
//   stall_cnt      : load-use stalls taken (saturating)
//   flush_cnt      : redirects taken (saturating)
// ---------------------------------------------------------------------------
module next_pc_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int                ADDR_W     = 18,
  parameter int                INST_BYTES = pipe_ctrl_pkg::INST_BYTES,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0,
  parameter int                REG_W      = pipe_ctrl_pkg::REG_W,
  parameter int                CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_cur,
  input  logic              ex_mem_read,
  input  logic [REG_W-1:0]  ex_rt,
  input  logic [REG_W-1:0]  id_rs,
  input  logic [REG_W-1:0]  id_rt,
  input  logic              id_uses_rt,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_target,
  input  logic              jmp_valid,
  input  logic [ADDR_W-1:0] jmp_target,
`ifdef NEXT_PC_MEM_WAIT_EN
  input  logic              imem_ready,
`endif
  output logic [ADDR_W-1:0] pc_next,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              ifid_flush,
  output logic              idex_bubble,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  stall_cnt_q, flush_cnt_q;
  logic              stall_inc, flush_inc;
  logic              hazard;

`ifdef NEXT_PC_MEM_WAIT_EN
  logic              pend_q, pend_d;
  logic [ADDR_W-1:0] pend_tgt_q, pend_tgt_d;
`endif

  lu_hazard_detect #(.W(REG_W)) u_hazard (
    .ex_mem_read_i (ex_mem_read),
    .ex_rt_i       (ex_rt),
    .id_rs_i       (id_rs),
    .id_rt_i       (id_rt),
    .id_uses_rt_i  (id_uses_rt),
    .hazard_o      (hazard)
  );

  // Decision logic, in priority order: rst > br_taken > (mem wait) > hazard > jump > sequential.
  always_comb begin
    // NOTE: every signal written here gets a default first so no path can infer a latch.
    pc_next     = pc_cur + ADDR_W'(INST_BYTES);  // wraps naturally at 2^ADDR_W
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    state_d     = RUN;
    stall_inc   = 1'b0;
    flush_inc   = 1'b0;
`ifdef NEXT_PC_MEM_WAIT_EN
    pend_d      = pend_q;
    pend_tgt_d  = pend_tgt_q;
`endif

    if (rst) begin
      pc_next     = RESET_PC;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (br_taken) begin
`ifdef NEXT_PC_MEM_WAIT_EN
      if (!imem_ready) begin
        // Fetch cannot accept the redirect yet: park it and hold everything.
        pend_d      = 1'b1;
        pend_tgt_d  = br_target;
        pc_next     = pc_cur;
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
        state_d     = state_q;
      end else
`endif
      begin
        pc_next     = br_target;
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
        flush_inc   = 1'b1;
        state_d     = SQUASH;
`ifdef NEXT_PC_MEM_WAIT_EN
        pend_d      = 1'b0;
`endif
      end
`ifdef NEXT_PC_MEM_WAIT_EN
    end else if (!imem_ready) begin
      pc_next    = pc_cur;
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      ifid_flush = 1'b1;
      state_d    = state_q;
    end else if (pend_q) begin
      pc_next     = pend_tgt_q;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      flush_inc   = 1'b1;
      state_d     = SQUASH;
      pend_d      = 1'b0;
`endif
    end else if (hazard && (state_q == RUN)) begin
      // Hold PC and IF/ID for one cycle and feed ID/EX a bubble so the load completes.
      pc_next     = pc_cur;
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
      stall_inc   = 1'b1;
      state_d     = STALL;
    end else if (jmp_valid && (state_q != SQUASH)) begin
      // Jump resolves in ID, so only the slot behind it in IF/ID is wrong.
      pc_next    = jmp_target;
      ifid_flush = 1'b1;
      flush_inc  = 1'b1;
      state_d    = SQUASH;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
`ifdef NEXT_PC_MEM_WAIT_EN
      pend_q      <= 1'b0;
      pend_tgt_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      if (stall_inc && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 1'b1;
      if (flush_inc && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + 1'b1;
`ifdef NEXT_PC_MEM_WAIT_EN
      pend_q     <= pend_d;
      pend_tgt_q <= pend_tgt_d;
`endif
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule : next_pc_ctrl
